sui_simd_reg_upstream: RTL and testbench
========================================

# sui_simd_reg_upstream

Stack-upstream-interface (sui) side of the SIMD register handoff. The block monitors the per-lane result registers, valid bits and tag driven by the SIMD wrapper. Once every enabled lane is valid, it snapshots them and serializes a packet (header beat plus one beat per enabled lane) onto the upstream stack bus using a valid/ready handshake. It then pulses `sui__simd__regs_complete` so the SIMD wrapper clears its valid bits, and it waits for that clear to be observed before re-arming.

## Interface
Parameters:
- `NUM_LANES`, 32, number of SIMD execution lanes (≥1)
- `LANE_WIDTH`, 32, width of one lane result (≥32)
- `TAG_WIDTH`, 8, stack OOB tag width
- `PE_ID_WIDTH`, 8, PE identifier width
- `LANE_ID_WIDTH`, `$clog2(NUM_LANES)` (min 1), lane index width

Ports (clock and reset first):
- `clk`  in  1  single clock; all state on rising edge
- `reset_poweron`  in  1  asynchronous, active-low reset
- `peId`  in  PE_ID_WIDTH  this PE's id, quasi-static
- `cntl__sui__lane_enable`  in  NUM_LANES  lanes participating in the current operation
- `simd__sui__tag`  in  TAG_WIDTH  tag of the current result set
- `simd__sui__regs`  in  NUM_LANES*LANE_WIDTH  flattened lane results; lane i at `[i*LANE_WIDTH +: LANE_WIDTH]`
- `simd__sui__regs_valid`  in  NUM_LANES  per-lane result valid
- `sui__simd__regs_complete`  out  1  one-cycle pulse: packet fully sent
- `sui__sys__valid`  out  1  beat valid
- `sys__sui__ready`  in  1  downstream accepts beat
- `sui__sys__cntl`  out  2  beat type: 2'b01 SOP (header), 2'b00 MOP, 2'b10 EOP
- `sui__sys__lane`  out  LANE_ID_WIDTH  lane index of data beat; 0 on header
- `sui__sys__data`  out  LANE_WIDTH  header word or lane result

## Operation
- Trigger in IDLE: `en = cntl__sui__lane_enable`, `en != 0` and `(simd__sui__regs_valid & en) == en`.
- On trigger, capture the following in one edge: `en` into `mask_q`, all lane results, `simd__sui__tag`, and `cnt = popcount(en)`. Go to HDR.
- Inputs changing after capture are ignored until the next trigger.
- HDR: `valid=1`, `cntl=01`, `lane=0`, `data = {zero-pad, cnt[7:0], peId, tag}`. The header fields are packed from the LSB: tag at [TAG_WIDTH-1:0], peId next, then the 8-bit count. On handshake, go to DATA.
- DATA: present the lowest set bit `k` of `mask_q`: `lane=k`, `data=result_q[k]`.
  - `cntl=10` if k is the last remaining set bit, else `00`.
  - On handshake, clear bit k. After the EOP handshake, go to CMPL.
- CMPL: `sui__simd__regs_complete=1` for exactly one cycle, `valid=0`. Go to WCLR.
- WCLR: wait until `(simd__sui__regs_valid & cntl__sui__lane_enable) == 0`, then go to IDLE. This blocks retriggering on stale valids; the SIMD wrapper clears its valids 2 cycles after the complete pulse.
- Handshake rules:
  - A beat transfers when `valid && ready`.
  - Once `valid` is asserted, `valid`, `cntl`, `lane` and `data` stay stable until the beat is accepted.
  - `ready` may toggle arbitrarily; `valid` never depends combinationally on `ready`.
- Packet length is always `cnt+1` beats. A single-lane packet is SOP followed by EOP.

## Timing
- Reset (async assert, sync release): state IDLE. Outputs: `sui__sys__valid=0`, `sui__sys__cntl=00`, `sui__sys__lane=0`, `sui__sys__data=0`, `sui__simd__regs_complete=0`. All snapshots cleared.
- Reset asserted mid-packet: `valid` drops immediately with no EOP. After release the block re-evaluates the trigger from IDLE.
- Latency: trigger true in cycle t → header valid in cycle t+1.
- With `ready` held high, beats are back-to-back:
  - SOP in t+1, first data beat in t+2, EOP in t+1+cnt.
  - Complete pulse in t+2+cnt.
- Minimum re-arm: two cycles after the complete pulse (WCLR exit). No new packet can start before the valids clear.
- All outputs are registered or decoded purely from state and snapshot registers.

## Test plan
- NUM_LANES=4, en=4'b1111, results 0x11/0x22/0x33/0x44, tag 0x5A, peId 3, ready=1:
  - Beats SOP data=0x0004_035A, then lanes 0,1,2 MOP 0x11,0x22,0x33, then lane 3 EOP 0x44.
  - Complete pulse one cycle after EOP, exactly one cycle wide.
- en=4'b1010, all valids set: SOP with cnt=2, then lane 1 MOP, then lane 3 EOP. Lanes 0 and 2 are never emitted.
- Backpressure: ready low for 3 cycles during the lane 2 beat. That beat holds valid, lane and data unchanged for 3 cycles. Total packet length remains 5 beats.
- Valids arrive one lane per cycle: there is no trigger until the last enabled lane is valid. After complete, valids held high for 5 extra cycles produce no second packet. Clearing then setting the valids again produces a new packet.
- Single lane, en=4'b0100: SOP cnt=1, then lane 2 EOP, then complete.
- Assert reset during the second data beat: valid drops within the same cycle, outputs return to reset values, and no complete pulse is generated.

Source files
------------

// File: rtl/sui_simd_reg_upstream.sv
// Upstream side of the SIMD register handoff: snapshots valid lane results
// and serializes them as a header plus one beat per enabled lane.
module sui_simd_reg_upstream #(
    parameter int NUM_LANES     = 32,
    parameter int LANE_WIDTH    = 32,
    parameter int TAG_WIDTH     = 8,
    parameter int PE_ID_WIDTH   = 8,
    parameter int LANE_ID_WIDTH = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                            clk,
    input  logic                            reset_poweron,
    input  logic [PE_ID_WIDTH-1:0]          peId,
    input  logic [NUM_LANES-1:0]            cntl__sui__lane_enable,
    input  logic [TAG_WIDTH-1:0]            simd__sui__tag,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] simd__sui__regs,
    input  logic [NUM_LANES-1:0]            simd__sui__regs_valid,
    output logic                            sui__simd__regs_complete,
    output logic                            sui__sys__valid,
    input  logic                            sys__sui__ready,
    output logic [1:0]                      sui__sys__cntl,
    output logic [LANE_ID_WIDTH-1:0]        sui__sys__lane,
    output logic [LANE_WIDTH-1:0]           sui__sys__data
);

    localparam int CNT_RAW = $clog2(NUM_LANES + 1);
    localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

    localparam logic [1:0] CNTL_SOP = 2'b01;
    localparam logic [1:0] CNTL_MOP = 2'b00;
    localparam logic [1:0] CNTL_EOP = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CMPL,
        S_WCLR
    } state_e;

    state_e state_q, state_d;

    logic [NUM_LANES-1:0]                 mask_q, mask_d;
    logic [NUM_LANES-1:0][LANE_WIDTH-1:0] result_q, result_d;
    logic [TAG_WIDTH-1:0]                 tag_q, tag_d;
    logic [PE_ID_WIDTH-1:0]               pe_q, pe_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;

    logic                     trigger;
    logic                     en_clear;
    logic [CNT_W-1:0]         en_cnt;
    logic [LANE_ID_WIDTH-1:0] lane_k;
    logic [NUM_LANES-1:0]     low_oh;
    logic [NUM_LANES-1:0]     rest_mask;
    logic                     last_lane;
    logic [LANE_WIDTH-1:0]    hdr_word;

    // Trigger needs every enabled lane valid; an empty enable never fires.
    assign trigger  = (cntl__sui__lane_enable != '0) &&
                      ((simd__sui__regs_valid & cntl__sui__lane_enable)
                       == cntl__sui__lane_enable);
    assign en_clear = (simd__sui__regs_valid & cntl__sui__lane_enable) == '0;

    always_comb begin
        en_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            en_cnt = en_cnt + CNT_W'(cntl__sui__lane_enable[i]);
        end
    end

    always_comb begin
        lane_k = '0;
        low_oh = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                lane_k    = LANE_ID_WIDTH'(i);
                low_oh    = '0;
                low_oh[i] = 1'b1;
            end
        end
    end

    assign rest_mask = mask_q & ~low_oh;
    assign last_lane = (rest_mask == '0);

    always_comb begin
        hdr_word = '0;
        hdr_word[TAG_WIDTH-1:0]                  = tag_q;
        hdr_word[TAG_WIDTH +: PE_ID_WIDTH]       = pe_q;
        hdr_word[TAG_WIDTH + PE_ID_WIDTH +: 8]   = cnt_q[7:0];
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (trigger) state_d = S_HDR;
            S_HDR:  if (sys__sui__ready) state_d = S_DATA;
            S_DATA: if (sys__sui__ready && last_lane) state_d = S_CMPL;
            S_CMPL: state_d = S_WCLR;
            S_WCLR: if (en_clear) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sui__sys__valid          = 1'b0;
        sui__sys__cntl           = CNTL_MOP;
        sui__sys__lane           = '0;
        sui__sys__data           = '0;
        sui__simd__regs_complete = 1'b0;
        unique case (state_q)
            S_HDR: begin
                sui__sys__valid = 1'b1;
                sui__sys__cntl  = CNTL_SOP;
                sui__sys__data  = hdr_word;
            end
            S_DATA: begin
                sui__sys__valid = 1'b1;
                sui__sys__cntl  = last_lane ? CNTL_EOP : CNTL_MOP;
                sui__sys__lane  = lane_k;
                sui__sys__data  = result_q[lane_k];
            end
            S_CMPL: sui__simd__regs_complete = 1'b1;
            default: ;
        endcase
    end

    // Snapshot is taken only on the trigger edge; later input churn is ignored.
    always_comb begin
        mask_d   = mask_q;
        result_d = result_q;
        tag_d    = tag_q;
        pe_d     = pe_q;
        cnt_d    = cnt_q;
        if (state_q == S_IDLE && trigger) begin
            mask_d = cntl__sui__lane_enable;
            for (int i = 0; i < NUM_LANES; i++) begin
                result_d[i] = simd__sui__regs[i*LANE_WIDTH +: LANE_WIDTH];
            end
            tag_d = simd__sui__tag;
            pe_d  = peId;
            cnt_d = en_cnt;
        end else if (state_q == S_DATA && sys__sui__ready) begin
            mask_d = rest_mask;
        end
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            mask_q   <= '0;
            result_q <= '0;
            tag_q    <= '0;
            pe_q     <= '0;
            cnt_q    <= '0;
        end else begin
            mask_q   <= mask_d;
            result_q <= result_d;
            tag_q    <= tag_d;
            pe_q     <= pe_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sui_simd_reg_upstream.sv
// Scoreboard bench for sui_simd_reg_upstream with four lanes.
module tb_sui_simd_reg_upstream;

    localparam int NL = 4;
    localparam int LW = 32;

    logic          clk;
    logic          reset_poweron;
    logic [7:0]    peId;
    logic [NL-1:0] lane_en;
    logic [7:0]    tag;
    logic [NL*LW-1:0] regs;
    logic [NL-1:0] regs_valid;
    logic          complete;
    logic          valid;
    logic          ready;
    logic [1:0]    cntl;
    logic [1:0]    lane;
    logic [LW-1:0] data;

    sui_simd_reg_upstream #(
        .NUM_LANES(NL),
        .LANE_WIDTH(LW),
        .TAG_WIDTH(8),
        .PE_ID_WIDTH(8)
    ) dut (
        .clk(clk),
        .reset_poweron(reset_poweron),
        .peId(peId),
        .cntl__sui__lane_enable(lane_en),
        .simd__sui__tag(tag),
        .simd__sui__regs(regs),
        .simd__sui__regs_valid(regs_valid),
        .sui__simd__regs_complete(complete),
        .sui__sys__valid(valid),
        .sys__sui__ready(ready),
        .sui__sys__cntl(cntl),
        .sui__sys__lane(lane),
        .sui__sys__data(data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_cmpl;
        logic [1:0]  cntl;
        logic [1:0]  lane;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    task automatic exp_beat(input logic [1:0] c, input logic [1:0] l,
                            input logic [31:0] d);
        exp_t e;
        e.is_cmpl = 1'b0;
        e.cntl = c;
        e.lane = l;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic exp_cmpl();
        exp_t e;
        e.is_cmpl = 1'b1;
        e.cntl = 2'b00;
        e.lane = 2'b00;
        e.data = '0;
        q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every accepted beat or complete pulse.
    bit          prev_stall, prev_eop, prev_cmpl;
    logic [35:0] held;

    always @(negedge clk) begin
        if (!reset_poweron) begin
            prev_stall = 0;
            prev_eop   = 0;
            prev_cmpl  = 0;
        end else begin
            exp_t e;
            if (prev_stall)
                check({valid, cntl, lane, data} == {1'b1, held}, "stall_hold",
                      {valid, cntl, lane, data}, {1'b1, held});
            if (valid && ready) begin
                if (q.size() == 0) begin
                    check(0, "unexpected_beat", {cntl, lane, data}, '0);
                end else begin
                    e = q.pop_front();
                    check(!e.is_cmpl && {cntl, lane, data} ==
                          {e.cntl, e.lane, e.data}, "beat",
                          {cntl, lane, data},
                          {e.is_cmpl, 1'b0, e.cntl, e.lane, e.data});
                end
            end
            if (complete) begin
                check(!prev_cmpl, "cmpl_width", prev_cmpl, 0);
                check(prev_eop && !valid, "cmpl_after_eop",
                      {prev_eop, valid}, 2'b10);
                if (q.size() == 0) begin
                    check(0, "unexpected_cmpl", 1, 0);
                end else begin
                    e = q.pop_front();
                    check(e.is_cmpl, "cmpl_order", e.is_cmpl, 1);
                end
            end
            prev_stall = valid && !ready;
            held       = {cntl, lane, data};
            prev_eop   = valid && ready && cntl == 2'b10;
            prev_cmpl  = complete;
        end
    end

    task automatic set_regs(input logic [31:0] base);
        for (int i = 0; i < NL; i++) regs[i*LW +: LW] = base + i;
    endtask

    task automatic wait_cmpl(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!complete && n < 100);
        check(n < 100, name, n, 100);
    endtask

    // Wrapper model: valids drop two cycles after the complete pulse.
    task automatic wrapper_clear();
        @(posedge clk);
        @(posedge clk);
        #1 regs_valid = '0;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_lane_beat(input logic [1:0] l, input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(valid && lane == l && cntl == 2'b00) && n < 20);
        check(n < 20, name, n, 20);
    endtask

    initial begin
        reset_poweron = 1'b0;
        peId       = 8'h03;
        lane_en    = '0;
        tag        = 8'h5A;
        regs       = '0;
        regs_valid = '0;
        ready      = 1'b1;
        repeat (3) @(negedge clk);
        check(valid == 0, "rst_valid", valid, 0);
        check(cntl == 0, "rst_cntl", cntl, 0);
        check(lane == 0, "rst_lane", lane, 0);
        check(data == 0, "rst_data", data, 0);
        check(complete == 0, "rst_cmpl", complete, 0);
        @(posedge clk);
        #1 reset_poweron = 1'b1;
        repeat (2) @(posedge clk);

        // Full four-lane packet
        exp_beat(2'b01, 2'd0, 32'h0004_035A);
        exp_beat(2'b00, 2'd0, 32'h11);
        exp_beat(2'b00, 2'd1, 32'h22);
        exp_beat(2'b00, 2'd2, 32'h33);
        exp_beat(2'b10, 2'd3, 32'h44);
        exp_cmpl();
        #1;
        regs = {32'h44, 32'h33, 32'h22, 32'h11};
        lane_en = 4'b1111;
        regs_valid = 4'b1111;
        wait_cmpl("t1_cmpl");
        wrapper_clear();

        // Sparse mask: lanes 0 and 2 must never appear
        exp_beat(2'b01, 2'd0, 32'h0002_035A);
        exp_beat(2'b00, 2'd1, 32'hA1);
        exp_beat(2'b10, 2'd3, 32'hA3);
        exp_cmpl();
        #1;
        set_regs(32'hA0);
        lane_en = 4'b1010;
        regs_valid = 4'b1111;
        wait_cmpl("t2_cmpl");
        wrapper_clear();

        // Backpressure on lane 2
        exp_beat(2'b01, 2'd0, 32'h0004_0333);
        exp_beat(2'b00, 2'd0, 32'h100);
        exp_beat(2'b00, 2'd1, 32'h101);
        exp_beat(2'b00, 2'd2, 32'h102);
        exp_beat(2'b10, 2'd3, 32'h103);
        exp_cmpl();
        #1;
        set_regs(32'h100);
        tag = 8'h33;
        lane_en = 4'b1111;
        regs_valid = 4'b1111;
        wait_lane_beat(2'd2, "t3_find_lane2");
        ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready = 1'b1;
        wait_cmpl("t3_cmpl");
        wrapper_clear();

        // Valids trickle in; stale valids must not retrigger
        #1;
        set_regs(32'h200);
        tag = 8'h77;
        lane_en = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            regs_valid[i] = 1'b1;
            @(negedge clk);
            check(valid == 0, "t4_no_early", valid, 0);
            @(posedge clk);
            #1;
        end
        exp_beat(2'b01, 2'd0, 32'h0004_0377);
        for (int i = 0; i < 3; i++) exp_beat(2'b00, 2'(i), 32'h200 + i);
        exp_beat(2'b10, 2'd3, 32'h203);
        exp_cmpl();
        regs_valid[3] = 1'b1;
        wait_cmpl("t4_cmpl");
        repeat (5) begin
            @(negedge clk);
            check(valid == 0, "t4_no_retrigger", valid, 0);
        end
        @(posedge clk);
        #1 regs_valid = '0;
        repeat (2) @(posedge clk);
        exp_beat(2'b01, 2'd0, 32'h0004_0377);
        for (int i = 0; i < 3; i++) exp_beat(2'b00, 2'(i), 32'h200 + i);
        exp_beat(2'b10, 2'd3, 32'h203);
        exp_cmpl();
        #1 regs_valid = 4'b1111;
        wait_cmpl("t4_rearm_cmpl");
        wrapper_clear();

        // Single lane
        exp_beat(2'b01, 2'd0, 32'h0001_035A);
        exp_beat(2'b10, 2'd2, 32'h302);
        exp_cmpl();
        #1;
        set_regs(32'h300);
        tag = 8'h5A;
        lane_en = 4'b0100;
        regs_valid = 4'b0100;
        wait_cmpl("t5_cmpl");
        wrapper_clear();

        // Reset during the second data beat
        exp_beat(2'b01, 2'd0, 32'h0004_035A);
        exp_beat(2'b00, 2'd0, 32'h400);
        #1;
        set_regs(32'h400);
        lane_en = 4'b1111;
        regs_valid = 4'b1111;
        wait_lane_beat(2'd1, "t6_find_lane1");
        reset_poweron = 1'b0;
        #1;
        check(valid == 0, "t6_rst_valid", valid, 0);
        check(cntl == 0, "t6_rst_cntl", cntl, 0);
        check(lane == 0, "t6_rst_lane", lane, 0);
        check(data == 0, "t6_rst_data", data, 0);
        check(complete == 0, "t6_rst_cmpl", complete, 0);
        regs_valid = '0;
        repeat (3) @(posedge clk);
        #1 reset_poweron = 1'b1;
        repeat (6) @(negedge clk);
        check(valid == 0, "t6_idle_after", valid, 0);

        check(q.size() == 0, "queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
